// File: rtl/sprite_update_scheduler.sv
// Per-frame bouncing-box motion scheduler: on each accepted frame_tick, walks
// the sprite table, updating x then y/colour of one sprite per cycle through a
// single shared adder/comparator.
module sprite_update_scheduler #(
    parameter int unsigned NUM_SPRITES   = 4,
    parameter int unsigned SCREEN_WIDTH  = 640,
    parameter int unsigned SCREEN_HEIGHT = 480,
    parameter int unsigned BOX_SIZE      = 32,
    // Optional reset-value override; slot i holds sprite i (x/y 16-bit slots,
    // vx/vy 4-bit two's complement slots, colour 3-bit slots).
    parameter bit           PRELOAD       = 1'b0,
    parameter logic [111:0] PRELOAD_X     = '0,
    parameter logic [111:0] PRELOAD_Y     = '0,
    parameter logic [27:0]  PRELOAD_VX    = '0,
    parameter logic [27:0]  PRELOAD_VY    = '0,
    parameter logic [20:0]  PRELOAD_COLOR = '0
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          frame_tick,
    input  logic                                          pause,
    output logic [NUM_SPRITES*$clog2(SCREEN_WIDTH)-1:0]   sprite_x,
    output logic [NUM_SPRITES*$clog2(SCREEN_HEIGHT)-1:0]  sprite_y,
    output logic [NUM_SPRITES*3-1:0]                      sprite_color,
    output logic                                          busy,
    output logic                                          done,
    output logic                                          overrun
);

    localparam int unsigned XW = $clog2(SCREEN_WIDTH);
    localparam int unsigned YW = $clog2(SCREEN_HEIGHT);
    localparam int unsigned IW = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
    localparam logic [XW-1:0]        XMAX_U = XW'(SCREEN_WIDTH - BOX_SIZE);
    localparam logic [YW-1:0]        YMAX_U = YW'(SCREEN_HEIGHT - BOX_SIZE);
    localparam logic signed [XW+1:0] XMAX_S = $signed({2'b00, XMAX_U});
    localparam logic signed [YW+1:0] YMAX_S = $signed({2'b00, YMAX_U});
    localparam logic [IW-1:0]        LAST   = IW'(NUM_SPRITES - 1);

    typedef enum logic [1:0] {IDLE, UPD_X, UPD_Y, FINISH} state_t;

    state_t                 state_q, state_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic                   start;
    logic                   busy_q, done_q, overrun_q;

    logic [XW-1:0]          x_q     [NUM_SPRITES];
    logic [YW-1:0]          y_q     [NUM_SPRITES];
    logic [3:0]             vx_q    [NUM_SPRITES];
    logic [3:0]             vy_q    [NUM_SPRITES];
    logic [2:0]             color_q [NUM_SPRITES];
    logic [NUM_SPRITES-1:0] bounced_q;

    logic signed [XW+1:0]   tx;
    logic signed [YW+1:0]   ty;
    logic                   x_bounce, y_bounce;
    logic [XW-1:0]          x_new;
    logic [YW-1:0]          y_new;
    logic [2:0]             color_adv;

    // Next-state logic of the sweep sequencer.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        start   = 1'b0;
        case (state_q)
            IDLE: begin
                if (frame_tick && !pause) begin
                    state_d = UPD_X;
                    idx_d   = '0;
                    start   = 1'b1;
                end
            end
            UPD_X:  state_d = UPD_Y;
            UPD_Y: begin
                if (idx_q == LAST) begin
                    state_d = FINISH;
                end else begin
                    state_d = UPD_X;
                    idx_d   = idx_q + 1'b1;
                end
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register plus registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            busy_q  <= (state_d == UPD_X) || (state_d == UPD_Y);
            done_q  <= (state_d == FINISH);
            if (frame_tick && state_q != IDLE) overrun_q <= 1'b1;
        end
    end

    // Shared adder/comparator, operating on the sprite selected by idx_q.
    always_comb begin
        tx = $signed({2'b00, x_q[idx_q]}) + $signed({{(XW-2){vx_q[idx_q][3]}}, vx_q[idx_q]});
        ty = $signed({2'b00, y_q[idx_q]}) + $signed({{(YW-2){vy_q[idx_q][3]}}, vy_q[idx_q]});
        x_bounce = tx[XW+1] || (tx > XMAX_S);
        y_bounce = ty[YW+1] || (ty > YMAX_S);
        x_new = tx[XW+1] ? '0 : (tx > XMAX_S) ? XMAX_U : tx[XW-1:0];
        y_new = ty[YW+1] ? '0 : (ty > YMAX_S) ? YMAX_U : ty[YW-1:0];
        color_adv = (color_q[idx_q] == 3'd7) ? 3'd1 : color_q[idx_q] + 3'd1;
    end

    // Sprite table: reset values, then x in UPD_X and y/colour in UPD_Y.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
                if (PRELOAD) begin
                    x_q[i]     <= PRELOAD_X[i*16 +: XW];
                    y_q[i]     <= PRELOAD_Y[i*16 +: YW];
                    vx_q[i]    <= PRELOAD_VX[i*4 +: 4];
                    vy_q[i]    <= PRELOAD_VY[i*4 +: 4];
                    color_q[i] <= PRELOAD_COLOR[i*3 +: 3];
                end else begin
                    x_q[i]     <= XW'(16 + 64*i);
                    y_q[i]     <= YW'(16 + 48*i);
                    vx_q[i]    <= (i % 2 == 0) ? 4'h2 : 4'hE;
                    vy_q[i]    <= 4'h1;
                    color_q[i] <= 3'(i + 1);
                end
            end
            bounced_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) bounced_q <= '0;
                end
                UPD_X: begin
                    x_q[idx_q] <= x_new;
                    if (x_bounce) begin
                        vx_q[idx_q]      <= 4'd0 - vx_q[idx_q];
                        bounced_q[idx_q] <= 1'b1;
                    end
                end
                UPD_Y: begin
                    y_q[idx_q] <= y_new;
                    if (y_bounce) vy_q[idx_q] <= 4'd0 - vy_q[idx_q];
                    // An X bounce earlier in the sweep and a Y bounce now still advance once.
                    if (bounced_q[idx_q] || y_bounce) color_q[idx_q] <= color_adv;
                end
                default: ;
            endcase
        end
    end

    // Pack the sprite table onto the output buses.
    always_comb begin
        sprite_x     = '0;
        sprite_y     = '0;
        sprite_color = '0;
        for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
            sprite_x[i*XW +: XW]    = x_q[i];
            sprite_y[i*YW +: YW]    = y_q[i];
            sprite_color[i*3 +: 3]  = color_q[i];
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_sprite_update_scheduler.sv
// Self-checking bench for sprite_update_scheduler: vector table + sweep scoreboard,
// plus hand-written sequences for preload bounce, overrun, pause and mid-sweep reset.
module tb_sprite_update_scheduler;

    localparam int N    = 4;
    localparam int XW   = 10;
    localparam int YW   = 9;
    localparam int XMAX = 608;
    localparam int YMAX = 448;

    localparam logic [N*XW-1:0] RST_X = {10'd208, 10'd144, 10'd80, 10'd16};
    localparam logic [N*YW-1:0] RST_Y = {9'd160, 9'd112, 9'd64, 9'd16};
    localparam logic [N*3-1:0]  RST_C = {3'd4, 3'd3, 3'd2, 3'd1};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic frame_tick = 1'b0;
    logic pause = 1'b0;
    logic [N*XW-1:0] sprite_x;
    logic [N*YW-1:0] sprite_y;
    logic [N*3-1:0]  sprite_color;
    logic busy, done, overrun;

    logic p_tick = 1'b0;
    logic p_pause = 1'b0;
    logic [2*XW-1:0] p_x;
    logic [2*YW-1:0] p_y;
    logic [5:0]      p_color;
    logic p_busy, p_done, p_overrun;

    sprite_update_scheduler #(
        .NUM_SPRITES(N), .SCREEN_WIDTH(640), .SCREEN_HEIGHT(480), .BOX_SIZE(32)
    ) dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .pause(pause),
        .sprite_x(sprite_x), .sprite_y(sprite_y), .sprite_color(sprite_color),
        .busy(busy), .done(done), .overrun(overrun)
    );

    sprite_update_scheduler #(
        .NUM_SPRITES(2), .SCREEN_WIDTH(640), .SCREEN_HEIGHT(480), .BOX_SIZE(32),
        .PRELOAD(1'b1),
        .PRELOAD_X({80'd0, 16'd1, 16'd607}),
        .PRELOAD_Y({80'd0, 16'd100, 16'd448}),
        .PRELOAD_VX({20'd0, 4'hE, 4'h2}),
        .PRELOAD_VY({20'd0, 4'h1, 4'h1}),
        .PRELOAD_COLOR({15'd0, 3'd7, 3'd1})
    ) dut_p (
        .clk(clk), .rst(rst), .frame_tick(p_tick), .pause(p_pause),
        .sprite_x(p_x), .sprite_y(p_y), .sprite_color(p_color),
        .busy(p_busy), .done(p_done), .overrun(p_overrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Reference model of the sprite table.
    int mx[N], my[N], mvx[N], mvy[N], mc[N];

    typedef struct {
        logic [N*XW-1:0] x;
        logic [N*YW-1:0] y;
        logic [N*3-1:0]  c;
    } snap_t;

    snap_t sb[$];

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            mx[i]  = 16 + 64*i;
            my[i]  = 16 + 48*i;
            mvx[i] = (i % 2 == 0) ? 2 : -2;
            mvy[i] = 1;
            mc[i]  = i + 1;
        end
    endfunction

    function automatic void model_sweep();
        for (int i = 0; i < N; i++) begin
            int t;
            bit b;
            b = 0;
            t = mx[i] + mvx[i];
            if (t < 0) begin mx[i] = 0; mvx[i] = -mvx[i]; b = 1; end
            else if (t > XMAX) begin mx[i] = XMAX; mvx[i] = -mvx[i]; b = 1; end
            else mx[i] = t;
            t = my[i] + mvy[i];
            if (t < 0) begin my[i] = 0; mvy[i] = -mvy[i]; b = 1; end
            else if (t > YMAX) begin my[i] = YMAX; mvy[i] = -mvy[i]; b = 1; end
            else my[i] = t;
            if (b) mc[i] = (mc[i] == 7) ? 1 : mc[i] + 1;
        end
    endfunction

    function automatic snap_t model_snap();
        snap_t s;
        for (int i = 0; i < N; i++) begin
            s.x[i*XW +: XW] = XW'(mx[i]);
            s.y[i*YW +: YW] = YW'(my[i]);
            s.c[i*3 +: 3]   = 3'(mc[i]);
        end
        return s;
    endfunction

    task automatic check_reset(input string tag);
        check({tag, "_x"}, sprite_x, RST_X);
        check({tag, "_y"}, sprite_y, RST_Y);
        check({tag, "_color"}, sprite_color, RST_C);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_overrun"}, overrun, 0);
    endtask

    // One frame: tick (optionally paused), optional late tick at cycle late_tick, bounded wait.
    task automatic do_frame(input logic p, input int late_tick);
        snap_t e;
        snap_t now_s;
        int busy_cnt = 0;
        int done_cnt = 0;
        int done_at  = 0;
        @(negedge clk);
        frame_tick = 1'b1;
        pause = p;
        if (!p) begin
            model_sweep();
            sb.push_back(model_snap());
        end
        for (int c = 1; c <= 2*N + 4; c++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_at == 0) done_at = c;
                if (sb.size() == 0) check("sb_spurious_done", 1, 0);
                else begin
                    e = sb.pop_front();
                    check("sb_x", sprite_x, e.x);
                    check("sb_y", sprite_y, e.y);
                    check("sb_color", sprite_color, e.c);
                end
            end
            frame_tick = (c == late_tick);
            pause = 1'b0;
        end
        frame_tick = 1'b0;
        if (p) begin
            now_s = model_snap();
            check("pause_busy_cycles", busy_cnt, 0);
            check("pause_done", done_cnt, 0);
            check("pause_x", sprite_x, now_s.x);
            check("pause_y", sprite_y, now_s.y);
            check("pause_color", sprite_color, now_s.c);
        end else begin
            check("busy_cycles", busy_cnt, 2*N);
            check("done_cycle", done_at, 2*N + 1);
            check("done_pulses", done_cnt, 1);
        end
        if (sb.size() != 0) begin
            check("sb_drain", sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic p_frame();
        @(negedge clk);
        p_tick = 1'b1;
        @(negedge clk);
        p_tick = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    typedef struct {
        int frames;
        int spr;
        int x;
        int y;
        int color;
    } vec_t;

    initial begin
        vec_t vecs[5];
        int frames_done;
        int got_done;
        int busy_seen;

        vecs = '{'{1, 0, 18, 17, 1},
                 '{1, 1, 78, 65, 2},
                 '{40, 1, 0, 104, 2},
                 '{41, 1, 0, 105, 3},
                 '{42, 1, 2, 106, 3}};

        model_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset("reset");
        rst = 1'b0;

        // Preloaded instance: simultaneous X/Y bounce and colour wrap 7 -> 1.
        p_frame();
        check("pre1_x", p_x, {10'd0, 10'd608});
        check("pre1_y", p_y, {9'd101, 9'd448});
        check("pre1_color", p_color, {3'd1, 3'd2});
        p_frame();
        check("pre2_x", p_x, {10'd2, 10'd606});
        check("pre2_y", p_y, {9'd102, 9'd447});
        check("pre2_color", p_color, {3'd1, 3'd2});
        check("pre_overrun", p_overrun, 0);
        check("pre_busy", p_busy, 0);

        // Vector table: frame count, sprite, expected x/y/colour.
        frames_done = 0;
        for (int v = 0; v < 5; v++) begin
            while (frames_done < vecs[v].frames) begin
                do_frame(1'b0, 0);
                frames_done++;
            end
            check($sformatf("vec%0d_x", v), sprite_x[vecs[v].spr*XW +: XW], vecs[v].x);
            check($sformatf("vec%0d_y", v), sprite_y[vecs[v].spr*YW +: YW], vecs[v].y);
            check($sformatf("vec%0d_color", v), sprite_color[vecs[v].spr*3 +: 3], vecs[v].color);
        end
        check("overrun_clear", overrun, 0);

        // Tick during busy cycle 3 is dropped and flags overrun.
        do_frame(1'b0, 3);
        check("overrun_set", overrun, 1);

        // Paused tick: nothing happens; overrun stays sticky.
        do_frame(1'b1, 0);
        check("overrun_sticky", overrun, 1);

        // Reset asserted in cycle T+4 of a sweep.
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset("midrst");
        got_done = 0;
        busy_seen = 0;
        repeat (2*N + 4) begin
            @(negedge clk);
            if (done) got_done++;
            if (busy) busy_seen++;
        end
        check("midrst_no_done", got_done, 0);
        check("midrst_idle", busy_seen, 0);
        model_reset();

        do_frame(1'b0, 0);
        check("post_rst_s0_x", sprite_x[XW-1:0], 18);
        check("post_rst_s0_y", sprite_y[YW-1:0], 17);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule
